harq_soft_combiner: RTL and testbench

Parametrised HARQ soft-bit combiner for the RX decode chain. It accepts rate-matched LLR words from the de-rate-matcher and folds the circular-buffer repetitions of one code block into an Ncb-sized accumulator. Folding uses a write-first pass followed by saturating add passes. The result lands in one of two internal ping/pong banks, which the downstream HARQ sender drains through a bank-full/release handshake. It adds per-lane saturation, configurable widths and depth, read-after-write forwarding, and explicit bank ownership.

---
 rtl/harq_comb_pkg.sv | 32 +++
 rtl/harq_sdp_ram.sv | 22 ++
 rtl/harq_soft_combiner.sv | 182 ++++++++++++++++++
 tb/tb_harq_soft_combiner.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harq_comb_pkg.sv
// Shared types and the saturating lane adder for the HARQ soft combiner.
package harq_comb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BANK = 3'd1,
        RUN       = 3'd2,
        FLUSH     = 3'd3,
        DONE      = 3'd4
    } state_t;

    typedef logic bank_t;

    localparam int NUM_BANKS = 2;

    // Symmetric clamp to +/-(2^(acc_w-1)-1) so a combined LLR never lands on the
    // asymmetric most-negative code.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] acc,
        input logic signed [31:0] llr,
        input int                 acc_w
    );
        logic signed [31:0] lim;
        logic signed [31:0] sum;
        lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
        sum = acc + llr;
        if (sum > lim) return lim;
        if (sum < -lim) return -lim;
        return sum;
    endfunction

endpackage

// File: rtl/harq_sdp_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module harq_sdp_ram #(
    parameter int DATA_W = 160,
    parameter int ADDR_W = 11
) (
    input  logic              i_core_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge i_core_clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/harq_soft_combiner.sv
// HARQ soft-bit combiner: folds circular-buffer repetitions of one code block
// into a ping/pong accumulator bank that the HARQ sender drains and releases.
module harq_soft_combiner
    import harq_comb_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int IN_W   = 6,
    parameter int ACC_W  = 10,
    parameter int ADDR_W = 11
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rstn,
    input  logic                     i_soft_clr,
    input  logic                     i_cb_start,
    input  logic [3:0]               i_cb_user,
    input  logic [ADDR_W:0]          i_cb_ncb_words,
    input  logic [15:0]              i_cb_e_size,
    input  logic [15:0]              i_cb_ncb_size,
    output logic                     o_busy,
    input  logic                     i_llr_valid,
    output logic                     o_llr_ready,
    input  logic [LANES*IN_W-1:0]    i_llr_data,
    input  logic                     i_llr_last,
    output logic [1:0]               o_bank_full,
    output logic [7:0]               o_bank_user,
    output logic [31:0]              o_bank_amount,
    input  logic [1:0]               i_bank_release,
    input  logic                     i_drain_bank,
    input  logic [ADDR_W-1:0]        i_drain_addr,
    output logic [LANES*ACC_W-1:0]   o_drain_data,
    output state_t                   dbg_state
);

    localparam int DATA_W = LANES * ACC_W;

    // LLR handshake: a word transfers on every rising edge where both
    // i_llr_valid and o_llr_ready are high; o_llr_ready is high only in RUN.
    state_t state, state_nxt;
    bank_t  tgt;

    logic [3:0]        cb_user;
    logic [ADDR_W:0]   cb_ncb_words;
    logic [15:0]       cb_amount;
    logic [ADDR_W-1:0] wr_ptr;
    logic              pass;
    logic              accept;
    logic              ptr_wrap;

    logic                  s1_valid;
    logic [ADDR_W-1:0]     s1_addr;
    logic                  s1_pass;
    logic                  s1_fwd;
    logic [LANES*IN_W-1:0] s1_llr;
    logic [DATA_W-1:0]     fwd_word;
    logic [DATA_W-1:0]     old_word;
    logic [DATA_W-1:0]     wr_word;
    logic signed [ACC_W-1:0] old_lane;
    logic signed [IN_W-1:0]  llr_lane;

    logic [DATA_W-1:0] q_ping, q_pong;
    logic              own_ping, own_pong;
    logic              drain_bank_q;
    logic              drain_live;

    assign o_busy      = (state != IDLE);
    assign o_llr_ready = (state == RUN);
    assign dbg_state   = state;
    assign accept      = i_llr_valid && o_llr_ready;
    assign ptr_wrap    = ({1'b0, wr_ptr} == (cb_ncb_words - {{ADDR_W{1'b0}}, 1'b1}));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (i_cb_start) state_nxt = WAIT_BANK;
            WAIT_BANK: if (!o_bank_full[tgt]) state_nxt = RUN;
            RUN:       if (accept && i_llr_last) state_nxt = FLUSH;
            FLUSH:     state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state         <= IDLE;
            tgt           <= 1'b0;
            s1_valid      <= 1'b0;
            o_bank_full   <= '0;
            o_bank_user   <= '0;
            o_bank_amount <= '0;
            drain_live    <= 1'b0;
        end else if (i_soft_clr) begin
            state         <= IDLE;
            tgt           <= 1'b0;
            s1_valid      <= 1'b0;
            o_bank_full   <= '0;
            o_bank_user   <= '0;
            o_bank_amount <= '0;
            drain_live    <= 1'b0;
        end else begin
            state      <= state_nxt;
            s1_valid   <= accept;
            drain_live <= 1'b1;
            if (state == DONE) tgt <= ~tgt;
            // Publishing a finished block takes priority over a release of the same bank.
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (state == DONE && tgt == bank_t'(b)) begin
                    o_bank_full[b]          <= 1'b1;
                    o_bank_user[b*4 +: 4]   <= cb_user;
                    o_bank_amount[b*16 +: 16] <= cb_amount;
                end else if (i_bank_release[b]) begin
                    o_bank_full[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (state == IDLE && i_cb_start) begin
            cb_user      <= i_cb_user;
            cb_ncb_words <= i_cb_ncb_words;
            cb_amount    <= (i_cb_e_size < i_cb_ncb_size) ? i_cb_e_size : i_cb_ncb_size;
            wr_ptr       <= '0;
            pass         <= 1'b0;
        end else if (accept) begin
            if (ptr_wrap) begin
                wr_ptr <= '0;
                pass   <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
        if (accept) begin
            s1_addr <= wr_ptr;
            s1_pass <= pass;
            s1_llr  <= i_llr_data;
            // Only ncb_words=1 revisits an address one word later; RAM would return stale data.
            s1_fwd  <= s1_valid && (s1_addr == wr_ptr);
        end
        if (s1_valid) fwd_word <= wr_word;
        drain_bank_q <= i_drain_bank;
    end

    always_comb begin
        old_word = s1_fwd ? fwd_word : (tgt ? q_pong : q_ping);
        wr_word  = '0;
        old_lane = '0;
        llr_lane = '0;
        for (int k = 0; k < LANES; k++) begin
            old_lane = old_word[k*ACC_W +: ACC_W];
            llr_lane = s1_llr[k*IN_W +: IN_W];
            if (s1_pass)
                wr_word[k*ACC_W +: ACC_W] = ACC_W'(sat_add(32'(old_lane), 32'(llr_lane), ACC_W));
            else
                wr_word[k*ACC_W +: ACC_W] = ACC_W'(llr_lane);
        end
    end

    assign own_ping = o_busy && (tgt == 1'b0);
    assign own_pong = o_busy && (tgt == 1'b1);

    harq_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ping (
        .i_core_clk (i_core_clk),
        .we         (s1_valid && (tgt == 1'b0)),
        .wr_addr    (s1_addr),
        .wr_data    (wr_word),
        .rd_addr    (own_ping ? wr_ptr : i_drain_addr),
        .rd_data    (q_ping)
    );

    harq_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pong (
        .i_core_clk (i_core_clk),
        .we         (s1_valid && (tgt == 1'b1)),
        .wr_addr    (s1_addr),
        .wr_data    (wr_word),
        .rd_addr    (own_pong ? wr_ptr : i_drain_addr),
        .rd_data    (q_pong)
    );

    assign o_drain_data = drain_live ? (drain_bank_q ? q_pong : q_ping) : '0;

endmodule

// File: tb/tb_harq_soft_combiner.sv
// Directed bench for harq_soft_combiner: vector table of complete blocks plus
// hand-written sequences for bank stall, release/set collision, reset and clear.
module tb_harq_soft_combiner;
    import harq_comb_pkg::*;

    localparam int LANES  = 16;
    localparam int IN_W   = 6;
    localparam int ACC_W  = 10;
    localparam int ADDR_W = 11;
    localparam int DW     = LANES * ACC_W;
    localparam int IW     = LANES * IN_W;

    logic              core_clk = 1'b0;
    logic              rx_rstn = 1'b0;
    logic              soft_clr = 1'b0;
    logic              cb_start = 1'b0;
    logic [3:0]        cb_user = '0;
    logic [ADDR_W:0]   cb_ncb_words = '0;
    logic [15:0]       cb_e_size = '0;
    logic [15:0]       cb_ncb_size = '0;
    logic              busy;
    logic              llr_valid = 1'b0;
    logic              llr_ready;
    logic [IW-1:0]     llr_data = '0;
    logic              llr_last = 1'b0;
    logic [1:0]        bank_full;
    logic [7:0]        bank_user;
    logic [31:0]       bank_amount;
    logic [1:0]        bank_release = '0;
    logic              drain_bank = 1'b0;
    logic [ADDR_W-1:0] drain_addr = '0;
    logic [DW-1:0]     drain_data;
    state_t            dbg_state;

    harq_soft_combiner #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .i_core_clk     (core_clk),
        .i_rx_rstn      (rx_rstn),
        .i_soft_clr     (soft_clr),
        .i_cb_start     (cb_start),
        .i_cb_user      (cb_user),
        .i_cb_ncb_words (cb_ncb_words),
        .i_cb_e_size    (cb_e_size),
        .i_cb_ncb_size  (cb_ncb_size),
        .o_busy         (busy),
        .i_llr_valid    (llr_valid),
        .o_llr_ready    (llr_ready),
        .i_llr_data     (llr_data),
        .i_llr_last     (llr_last),
        .o_bank_full    (bank_full),
        .o_bank_user    (bank_user),
        .o_bank_amount  (bank_amount),
        .i_bank_release (bank_release),
        .i_drain_bank   (drain_bank),
        .i_drain_addr   (drain_addr),
        .o_drain_data   (drain_data),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 core_clk = ~core_clk;

    int unsigned cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [IW-1:0] lane_word(input int v);
        logic [31:0] t;
        logic [IW-1:0] w;
        t = v;
        for (int k = 0; k < LANES; k++) w[k*IN_W +: IN_W] = t[IN_W-1:0];
        return w;
    endfunction

    function automatic logic [DW-1:0] acc_word(input int v);
        logic [31:0] t;
        logic [DW-1:0] w;
        t = v;
        for (int k = 0; k < LANES; k++) w[k*ACC_W +: ACC_W] = t[ACC_W-1:0];
        return w;
    endfunction

    // Fill pattern: lane k holds k+1 on even words and -(k+1) on odd words.
    function automatic int fill_val(input int w, input int k);
        return (w % 2 == 0) ? (k + 1) : -(k + 1);
    endfunction

    // ---------------- driver tasks (entered and left on a negedge) ----------------
    task automatic start_block(input int user, input int nw, input int e, input int ncb);
        cb_user      = 4'(user);
        cb_ncb_words = (ADDR_W+1)'(nw);
        cb_e_size    = 16'(e);
        cb_ncb_size  = 16'(ncb);
        cb_start     = 1'b1;
        @(negedge core_clk);
        cb_start     = 1'b0;
    endtask

    task automatic send_word(input logic [IW-1:0] d, input logic last);
        int n;
        n = 0;
        llr_valid = 1'b1;
        llr_data  = d;
        llr_last  = last;
        while (!llr_ready && n < 200) begin
            @(negedge core_clk);
            n++;
        end
        if (!llr_ready) check("ready_timeout", 64'(llr_ready), 64'd1);
        @(negedge core_clk);
        llr_valid = 1'b0;
        llr_last  = 1'b0;
    endtask

    task automatic wait_full(input int b);
        int n;
        n = 0;
        while (!bank_full[b] && n < 200) begin
            @(negedge core_clk);
            n++;
        end
        if (!bank_full[b]) check("full_timeout", 64'(bank_full), 64'(1 << b));
    endtask

    task automatic release_banks(input logic [1:0] mask);
        bank_release = mask;
        @(negedge core_clk);
        bank_release = '0;
    endtask

    task automatic drain_check(input int b, input int n);
        logic [31:0] bb;
        bb = b;
        for (int a = 0; a < n; a++) begin
            drain_bank = bb[0];
            drain_addr = ADDR_W'(a);
            @(negedge core_clk);
            if (exp_q.size() == 0) check("exp_q_empty", 64'd0, 64'd1);
            else check_word($sformatf("drain_b%0d_a%0d", b, a), drain_data, exp_q.pop_front());
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        int user;
        int nw;
        int n_words;
        int e;
        int ncb;
        int val;
        int exp0;
        int exp1;
        int exp2;
        int amount;
    } vec_t;

    function automatic vec_t mk(input int user, input int nw, input int n_words, input int e,
                                input int ncb, input int val, input int exp0, input int exp1,
                                input int exp2, input int amount);
        vec_t v;
        v.user = user; v.nw = nw; v.n_words = n_words; v.e = e; v.ncb = ncb;
        v.val = val; v.exp0 = exp0; v.exp1 = exp1; v.exp2 = exp2; v.amount = amount;
        return v;
    endfunction

    initial begin
        vec_t vecs [7];
        int   bank;
        int   n;
        int unsigned t0;
        logic [IW-1:0] d;
        logic [DW-1:0] e;
        logic [31:0] t;

        vecs[0] = mk(5,  2, 64, 1024, 32,  31,  511,  511, 0,  32);  // saturate high
        vecs[1] = mk(6,  2, 64, 1024, 32, -32, -511, -511, 0,  32);  // saturate low
        vecs[2] = mk(7,  1,  5,   80, 16,   3,   15,    0, 0,  16);  // forwarding
        vecs[3] = mk(8,  1,  1, 2000, 1024, 7,    7,    0, 0, 1024); // amount = Ncb
        vecs[4] = mk(10, 1,  1,  500, 1024, -5,  -5,    0, 0, 500);  // amount = E
        vecs[5] = mk(11, 3,  7,  112, 48,   1,    3,    2, 2,  48);  // uneven fold
        vecs[6] = mk(12, 1, 16,  256, 16,  31,  496,    0, 0,  16);  // just below clamp

        // Reset values
        repeat (3) @(negedge core_clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(llr_ready), 64'd0);
        check("rst_full", 64'(bank_full), 64'd0);
        check("rst_user", 64'(bank_user), 64'd0);
        check("rst_amount", 64'(bank_amount), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check_word("rst_drain", drain_data, '0);
        rx_rstn = 1'b1;
        @(negedge core_clk);

        // Fill only: ncb_words=4, E=64, lane values 1..16 with alternating sign
        t0 = cyc;
        start_block(9, 4, 64, 64);
        check("busy_rise", 64'(busy), 64'd1);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < LANES; k++) begin
                t = fill_val(w, k);
                d[k*IN_W +: IN_W]  = t[IN_W-1:0];
                e[k*ACC_W +: ACC_W] = t[ACC_W-1:0];
            end
            exp_q.push_back(e);
            send_word(d, w == 3);
        end
        wait_full(0);
        check("fill_latency", 64'(cyc - t0), 64'd8);
        check("fill_busy_fall", 64'(busy), 64'd0);
        check("fill_full", 64'(bank_full), 64'b01);
        check("fill_user", 64'(bank_user[3:0]), 64'd9);
        check("fill_amount", 64'(bank_amount[15:0]), 64'd64);
        drain_check(0, 4);
        release_banks(2'b01);
        check("fill_released", 64'(bank_full), 64'd0);
        bank = 1;

        // Table-driven blocks, alternating banks
        for (int i = 0; i < 7; i++) begin
            start_block(vecs[i].user, vecs[i].nw, vecs[i].e, vecs[i].ncb);
            for (int w = 0; w < vecs[i].n_words; w++)
                send_word(lane_word(vecs[i].val), w == vecs[i].n_words - 1);
            wait_full(bank);
            check($sformatf("v%0d_full", i), 64'(bank_full), 64'(1 << bank));
            check($sformatf("v%0d_user", i), 64'(bank_user[bank*4 +: 4]), 64'(vecs[i].user));
            check($sformatf("v%0d_amount", i), 64'(bank_amount[bank*16 +: 16]), 64'(vecs[i].amount));
            exp_q.push_back(acc_word(vecs[i].exp0));
            if (vecs[i].nw > 1) exp_q.push_back(acc_word(vecs[i].exp1));
            if (vecs[i].nw > 2) exp_q.push_back(acc_word(vecs[i].exp2));
            drain_check(bank, vecs[i].nw);
            release_banks(2'(1 << bank));
            check($sformatf("v%0d_released", i), 64'(bank_full), 64'd0);
            bank = 1 - bank;
        end

        // Ping/pong stall: two blocks left unreleased, third waits for bank0
        start_block(1, 1, 16, 16);
        send_word(lane_word(2), 1'b1);
        wait_full(0);
        start_block(2, 1, 16, 16);
        send_word(lane_word(4), 1'b1);
        wait_full(1);
        check("stall_both_full", 64'(bank_full), 64'b11);
        start_block(3, 1, 16, 16);
        repeat (4) @(negedge core_clk);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_ready", 64'(llr_ready), 64'd0);
        check("stall_state", 64'(dbg_state), 64'(WAIT_BANK));
        release_banks(2'b01);
        check("stall_ready_plus1", 64'(llr_ready), 64'd0);
        @(negedge core_clk);
        check("stall_ready_plus2", 64'(llr_ready), 64'd1);
        send_word(lane_word(6), 1'b1);
        wait_full(0);
        check("stall_full_after", 64'(bank_full), 64'b11);
        check("stall_user", 64'(bank_user), 64'h23);
        exp_q.push_back(acc_word(6));
        drain_check(0, 1);
        exp_q.push_back(acc_word(4));
        drain_check(1, 1);
        release_banks(2'b11);

        // Release and DONE on the same bank in one cycle: set wins
        start_block(4, 1, 16, 16);
        send_word(lane_word(-1), 1'b1);
        n = 0;
        while (dbg_state != DONE && n < 50) begin
            @(negedge core_clk);
            n++;
        end
        check("collide_reach_done", 64'(dbg_state), 64'(DONE));
        bank_release = 2'b10;
        @(negedge core_clk);
        bank_release = '0;
        check("collide_set_wins", 64'(bank_full), 64'b10);
        exp_q.push_back(acc_word(-1));
        drain_check(1, 1);
        release_banks(2'b10);
        check("collide_released", 64'(bank_full), 64'd0);

        // Reset in the middle of RUN abandons the block
        start_block(13, 4, 64, 64);
        for (int w = 0; w < 3; w++) send_word(lane_word(5), 1'b0);
        rx_rstn = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_full", 64'(bank_full), 64'd0);
        @(negedge core_clk);
        rx_rstn = 1'b1;
        @(negedge core_clk);
        start_block(14, 1, 16, 16);
        send_word(lane_word(9), 1'b1);
        wait_full(0);
        check("midrst_next_bank0", 64'(bank_full), 64'b01);
        exp_q.push_back(acc_word(9));
        drain_check(0, 1);

        // Soft clear drops bank state and returns the target to bank0
        soft_clr = 1'b1;
        @(negedge core_clk);
        soft_clr = 1'b0;
        check("clr_full", 64'(bank_full), 64'd0);
        check("clr_user", 64'(bank_user), 64'd0);
        check("clr_amount", 64'(bank_amount), 64'd0);
        start_block(15, 1, 16, 16);
        send_word(lane_word(-7), 1'b1);
        wait_full(0);
        check("clr_next_bank0", 64'(bank_full), 64'b01);
        check("clr_next_user", 64'(bank_user[3:0]), 64'd15);
        exp_q.push_back(acc_word(-7));
        drain_check(0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
